// File: rtl/pixel_acc_pkg.sv
// Shared types and mode encodings for the pixel-wise accelerator.
package pixel_acc_pkg;

   localparam logic [1:0] MODE_COPY   = 2'd0;
   localparam logic [1:0] MODE_INVERT = 2'd1;
   localparam logic [1:0] MODE_THRESH = 2'd2;
   localparam logic [1:0] MODE_RSVD   = 2'd3;

   typedef enum logic [1:0] {
      COPY   = MODE_COPY,
      INVERT = MODE_INVERT,
      THRESH = MODE_THRESH,
      RSVD   = MODE_RSVD
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/pixel_lane_op.sv
// Combinational single-pixel operator: copy, invert or threshold one lane.
module pixel_lane_op
   import pixel_acc_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) (
   input  logic [PIX_W-1:0] p,
   input  mode_t            mode,
   input  logic [PIX_W-1:0] thresh,
   output logic [PIX_W-1:0] q
);

   always_comb begin
      q = p;
      unique case (mode)
         INVERT:      q = {PIX_W{1'b1}} - p;
         THRESH:      q = (p >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
         COPY, RSVD:  q = p;
         default:     q = p;
      endcase
   end

endmodule

// File: rtl/pixel_op_acc.sv
// Pixel-wise image accelerator: reads N packed words, writes f(word) to OUT_OFFSET+i.
// Optional run cycle counter on port `cycles` when PIXEL_ACC_PERF_EN is defined.
module pixel_op_acc
   import pixel_acc_pkg::*;
#(
   parameter int unsigned IMG_W      = 352,
   parameter int unsigned IMG_H      = 288,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned OUT_OFFSET = IMG_W * IMG_H * PIX_W / DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [PIX_W-1:0]  thresh,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] dataR,
   output logic [DATA_W-1:0] dataW,
   output logic              en,
   output logic              we,
   output logic              finish
`ifdef PIXEL_ACC_PERF_EN
   ,
   output logic [31:0]       cycles
`endif
);

   localparam int unsigned N     = IMG_W * IMG_H * PIX_W / DATA_W;
   localparam int unsigned L     = DATA_W / PIX_W;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if (DATA_W % PIX_W != 0) begin : g_bad_pix_w
      $error("DATA_W must be a multiple of PIX_W");
   end
   if (64'(OUT_OFFSET) + 64'(N) - 64'd1 >= (64'd1 << ADDR_W)) begin : g_bad_offset
      $error("OUT_OFFSET + N - 1 does not fit in ADDR_W bits");
   end

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   mode_t              mode_q;
   logic [PIX_W-1:0]   thresh_q;
   logic [DATA_W-1:0]  op_word;
   logic               start_edge;

   assign start_edge = (state_q == IDLE) && start;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         mode_q   <= COPY;
         thresh_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         // Operation is frozen for the whole run.
         if (start_edge) begin
            mode_q   <= mode_t'(mode);
            thresh_q <= thresh;
         end
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_lane
      pixel_lane_op #(
         .PIX_W (PIX_W)
      ) u_lane (
         .p      (dataR[k*PIX_W +: PIX_W]),
         .mode   (mode_q),
         .thresh (thresh_q),
         .q      (op_word[k*PIX_W +: PIX_W])
      );
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr    = '0;
      dataW   = '0;
      en      = 1'b0;
      we      = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               idx_d   = '0;
            end
         end
         READ: begin
            en      = 1'b1;
            addr    = ADDR_W'(idx_q);
            state_d = WRITE;
         end
         WRITE: begin
            en    = 1'b1;
            we    = 1'b1;
            addr  = ADDR_W'(OUT_OFFSET) + ADDR_W'(idx_q);
            dataW = op_word;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = READ;
            end
         end
         DONE: begin
            finish = 1'b1;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef PIXEL_ACC_PERF_EN
   logic [31:0] cycles_q;

   // Cleared when a run starts, held through DONE/IDLE for readout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycles_q <= '0;
      end else if (start_edge) begin
         cycles_q <= '0;
      end else if (state_q == READ || state_q == WRITE) begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_pixel_op_acc.sv
// Self-checking bench for pixel_op_acc: small-image cycle model plus one full-size run.
module tb_pixel_op_acc;

   localparam int unsigned PW    = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 16;
   localparam int unsigned LANES = DW / PW;
   localparam int unsigned SN    = 8 * 2 * PW / DW;
   localparam int unsigned SOFF  = SN;
   localparam int unsigned BN    = 352 * 288 * PW / DW;
   localparam int unsigned BOFF  = BN;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small DUT (8x2 image)
   logic          reset, start, en, we, finish;
   logic [1:0]    mode;
   logic [PW-1:0] thresh;
   logic [AW-1:0] addr;
   logic [DW-1:0] dataR, dataW;
   logic [31:0]   cycles;

   // Full-size DUT
   logic          breset, bstart, ben, bwe, bfinish;
   logic [1:0]    bmode;
   logic [PW-1:0] bthresh;
   logic [AW-1:0] baddr;
   logic [DW-1:0] bdataR, bdataW;
   logic [31:0]   bcycles;

   pixel_op_acc #(
      .IMG_W (8), .IMG_H (2), .PIX_W (PW), .DATA_W (DW), .ADDR_W (AW), .OUT_OFFSET (SOFF)
   ) u_dut (
      .clk (clk), .reset (reset), .start (start), .mode (mode), .thresh (thresh),
      .addr (addr), .dataR (dataR), .dataW (dataW), .en (en), .we (we), .finish (finish)
`ifdef PIXEL_ACC_PERF_EN
      , .cycles (cycles)
`endif
   );

   pixel_op_acc u_dut_big (
      .clk (clk), .reset (breset), .start (bstart), .mode (bmode), .thresh (bthresh),
      .addr (baddr), .dataR (bdataR), .dataW (bdataW), .en (ben), .we (bwe), .finish (bfinish)
`ifdef PIXEL_ACC_PERF_EN
      , .cycles (bcycles)
`endif
   );

`ifndef PIXEL_ACC_PERF_EN
   assign cycles  = '0;
   assign bcycles = '0;
`endif

   // Memories, loaded from the bench's input copies on request
   logic [DW-1:0] sin  [SN];
   logic [DW-1:0] smem [2*SN];
   logic [DW-1:0] bin  [BN];
   logic [DW-1:0] bmem [2*BN];
   logic          load_req = 1'b0;
   logic          bload_req = 1'b0;

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < SN; i++) begin
            smem[i]        <= sin[i];
            smem[SOFF + i] <= 32'hDEADBEEF;
         end
      end else if (en) begin
         if (we) smem[addr] <= dataW;
         else    dataR      <= smem[addr];
      end
   end

   always @(posedge clk) begin
      if (bload_req) begin
         for (int i = 0; i < BN; i++) begin
            bmem[i]        <= bin[i];
            bmem[BOFF + i] <= 32'hDEADBEEF;
         end
      end else if (ben) begin
         if (bwe) bmem[baddr] <= bdataW;
         else     bdataR      <= bmem[baddr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Per-pixel rule applied lane by lane
   function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w, input int m,
                                              input logic [PW-1:0] t);
      logic [DW-1:0] r;
      logic [PW-1:0] p, q;
      logic [PW-1:0] maxv;
      maxv = PW'((1 << PW) - 1);
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         p = w[k*PW +: PW];
         if (m == 1)      q = maxv - p;
         else if (m == 2) q = (p >= t) ? maxv : '0;
         else             q = p;
         r[k*PW +: PW] = q;
      end
      return r;
   endfunction

   // Reference model: m_k = cycles elapsed since the start edge
   bit            m_active = 1'b0;
   int            m_k = 0;
   int            m_mode = 0;
   logic [PW-1:0] m_thresh = '0;
   bit            cmp_on = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         m_active <= 1'b0;
         m_k      <= 0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_mode   <= int'(mode);
            m_thresh <= thresh;
         end
      end else if (m_k < 2 * SN + 1) begin
         m_k <= m_k + 1;
      end else if (!start) begin
         m_active <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         if (!m_active) begin
            chk("idle_en", en, 0);
            chk("idle_we", we, 0);
            chk("idle_finish", finish, 0);
            chk("idle_addr", addr, 0);
            chk("idle_dataW", dataW, 0);
         end else if (m_k <= 2 * SN) begin
            chk("run_en", en, 1);
            chk("run_finish", finish, 0);
            if (m_k % 2 == 0) begin
               chk("write_we", we, 1);
               chk("write_addr", addr, SOFF + m_k / 2 - 1);
               chk("write_dataW", dataW, ref_word(sin[m_k/2-1], m_mode, m_thresh));
            end else begin
               chk("read_we", we, 0);
               chk("read_addr", addr, (m_k - 1) / 2);
            end
         end else begin
            chk("done_finish", finish, 1);
            chk("done_en", en, 0);
            chk("done_we", we, 0);
         end
      end
   end

   task automatic load_small();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic load_plan();
      sin[0] = 32'h00FF7F80;
      sin[1] = 32'h01020304;
      sin[2] = 32'hFFFFFFFF;
      sin[3] = 32'h00000000;
      load_small();
   endtask

   // drop_after: cycle index at which start is released (0 = hold until finish)
   task automatic small_run(input int m, input logic [PW-1:0] t, input int drop_after,
                            input int hold_after);
      int fin_k;
      @(negedge clk);
      mode   = 2'(m);
      thresh = t;
      start  = 1'b1;
      fin_k  = -1;
      for (int n = 1; n <= 2 * SN + 20; n++) begin
         @(negedge clk);
         if (n == drop_after) start = 1'b0;
         if (finish) begin
            fin_k = n;
            break;
         end
      end
      chk("finish_latency", 64'(fin_k), 64'(2 * SN + 1));
`ifdef PIXEL_ACC_PERF_EN
      chk("cycles_at_finish", cycles, 2 * SN);
`endif
      repeat (hold_after) @(negedge clk);
`ifdef PIXEL_ACC_PERF_EN
      if (hold_after > 0) chk("cycles_held_done", cycles, 2 * SN);
`endif
      start = 1'b0;
      @(negedge clk);
      chk("finish_dropped", finish, 0);
      @(negedge clk);
`ifdef PIXEL_ACC_PERF_EN
      chk("cycles_held_idle", cycles, 2 * SN);
`endif
   endtask

   task automatic check_mem(input int m, input logic [PW-1:0] t);
      for (int i = 0; i < SN; i++) begin
         chk($sformatf("out_word%0d", SOFF + i), smem[SOFF + i], ref_word(sin[i], m, t));
         chk($sformatf("in_word%0d", i), smem[i], sin[i]);
      end
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad_out, bad_in, bfin;
      int m, drop, hold;
      logic [PW-1:0] t;

      reset = 1'b0; start = 1'b0; mode = '0; thresh = '0;
      breset = 1'b0; bstart = 1'b0; bmode = '0; bthresh = '0;
      repeat (3) @(negedge clk);
      chk("rst_addr", addr, 0);
      chk("rst_dataW", dataW, 0);
      chk("rst_en", en, 0);
      chk("rst_we", we, 0);
      chk("rst_finish", finish, 0);
`ifdef PIXEL_ACC_PERF_EN
      chk("rst_cycles", cycles, 0);
`endif
      reset  = 1'b1;
      breset = 1'b1;
      cmp_on = 1'b1;

      // Copy
      load_plan();
      small_run(0, 8'h00, 0, 0);
      chk("copy_w4", smem[4], 32'h00FF7F80);
      chk("copy_w5", smem[5], 32'h01020304);
      chk("copy_w6", smem[6], 32'hFFFFFFFF);
      chk("copy_w7", smem[7], 32'h00000000);

      // Invert
      load_plan();
      small_run(1, 8'h00, 0, 0);
      chk("inv_w4", smem[4], 32'hFF00807F);
      chk("inv_w5", smem[5], 32'hFEFDFCFB);
      chk("inv_w6", smem[6], 32'h00000000);
      chk("inv_w7", smem[7], 32'hFFFFFFFF);

      // Threshold at 0x80
      load_plan();
      small_run(2, 8'h80, 0, 0);
      chk("thr_w4", smem[4], 32'h00FF00FF);
      chk("thr_w5", smem[5], 32'h00000000);
      chk("thr_w6", smem[6], 32'hFFFFFFFF);
      chk("thr_w7", smem[7], 32'h00000000);

      // Reset sampled at E0+4: only word 4 written
      load_plan();
      @(negedge clk);
      mode = 2'd1; thresh = '0; start = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("midrst_en", en, 0);
      chk("midrst_we", we, 0);
      chk("midrst_finish", finish, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_w4", smem[4], 32'hFF00807F);
      chk("midrst_w5", smem[5], 32'hDEADBEEF);
      small_run(0, 8'h00, 0, 0);
      check_mem(0, 8'h00);

      // Handshake: start held 10 cycles past finish
      load_plan();
      small_run(1, 8'h00, 0, 10);
      check_mem(1, 8'h00);

      // Randomised runs, some releasing start mid-run
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < SN; i++) sin[i] = $urandom;
         load_small();
         m    = int'($urandom_range(0, 3));
         t    = PW'($urandom_range(0, 255));
         drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * SN)) : 0;
         hold = int'($urandom_range(0, 3));
         small_run(m, t, drop, hold);
         check_mem(m, t);
      end

      // Full-size invert
      cmp_on = 1'b0;
      for (int i = 0; i < BN; i++) bin[i] = $urandom;
      @(negedge clk);
      bload_req = 1'b1;
      @(negedge clk);
      bload_req = 1'b0;
      bmode  = 2'd1;
      bstart = 1'b1;
      bfin   = -1;
      for (int n = 1; n <= 2 * BN + 50; n++) begin
         @(negedge clk);
         if (bfinish) begin
            bfin = n;
            break;
         end
      end
      chk("big_finish_latency", 64'(bfin), 64'd50689);
`ifdef PIXEL_ACC_PERF_EN
      chk("big_cycles", bcycles, 2 * BN);
`endif
      bstart = 1'b0;
      @(negedge clk);
      chk("big_finish_dropped", bfinish, 0);
      bad_out = 0;
      bad_in  = 0;
      for (int i = 0; i < BN; i++) begin
         if (bmem[BOFF + i] !== ref_word(bin[i], 1, '0)) bad_out++;
         if (bmem[i] !== bin[i]) bad_in++;
      end
      chk("big_out_bad_words", 64'(bad_out), 0);
      chk("big_in_bad_words", 64'(bad_in), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
